simmem_wr_outstanding_limiter: RTL and testbench



---
 rtl/simmem_wr_outstanding_limiter.sv | 119 +++++++++++
 tb/tb_simmem_wr_outstanding_limiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/simmem_wr_outstanding_limiter.sv
// Write-address admission gate: tracks outstanding writes per AXI ID and in total.
// Optional stall statistics are enabled with the SIMMEM_LIMITER_STATS_EN macro.

package simmem_pkg;

   parameter int unsigned IDWidth = 3;
   parameter int unsigned WriteRespBankTotalCapacity = 16;

   typedef struct packed {
      logic [IDWidth-1:0] id;
      logic [31:0]        addr;
      logic [7:0]         burst_len;
   } waddr_req_t;

endpackage

module simmem_wr_outstanding_limiter #(
   parameter int unsigned IDWidth  = simmem_pkg::IDWidth,
   parameter int unsigned MaxPerId = 4,
   parameter int unsigned MaxTotal = simmem_pkg::WriteRespBankTotalCapacity
) (
   input  logic                             clk_i,
   input  logic                             rst_i,

   input  logic                             waddr_in_valid_i,
   output logic                             waddr_in_ready_o,
   input  simmem_pkg::waddr_req_t           waddr_data_i,

   output logic                             waddr_out_valid_o,
   input  logic                             waddr_out_ready_i,
   output simmem_pkg::waddr_req_t           waddr_data_o,

   input  logic                             wresp_valid_i,
   input  logic                             wresp_ready_i,
   input  logic [IDWidth-1:0]               wresp_id_i,

   output logic [$clog2(MaxTotal+1)-1:0]    total_outstanding_o,
   output logic                             underflow_err_o,
   output logic [31:0]                      stall_cycles_o
);

   localparam int unsigned NumIds = 2 ** IDWidth;
   localparam int unsigned CntW   = $clog2(MaxPerId + 1);
   localparam int unsigned TotW   = $clog2(MaxTotal + 1);

   logic [CntW-1:0]    cnt_q [NumIds];
   logic [TotW-1:0]    total_q;
   logic               err_q;

   logic [IDWidth-1:0] req_id;
   logic               admit;
   logic               acc;
   logic               rsp_hs;
   logic               rel;

   // Admission looks only at registered counts, so a response never frees a slot in its own cycle.
   always_comb begin
      req_id = waddr_data_i.id;
      admit  = (cnt_q[req_id] < CntW'(MaxPerId)) && (total_q < TotW'(MaxTotal));
      acc    = waddr_in_valid_i && waddr_out_ready_i && admit;
      rsp_hs = wresp_valid_i && wresp_ready_i;
      rel    = rsp_hs && (cnt_q[wresp_id_i] != '0);
   end

   assign waddr_out_valid_o   = waddr_in_valid_i && admit;
   assign waddr_in_ready_o    = waddr_out_ready_i && admit;
   assign waddr_data_o        = waddr_data_i;
   assign total_outstanding_o = total_q;
   assign underflow_err_o     = err_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < NumIds; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NumIds; i++) begin
            if (acc && (req_id == IDWidth'(i)) && !(rel && (wresp_id_i == IDWidth'(i)))) begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end else if (rel && (wresp_id_i == IDWidth'(i)) && !(acc && (req_id == IDWidth'(i)))) begin
               cnt_q[i] <= cnt_q[i] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         total_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (acc && !rel) begin
            total_q <= total_q + 1'b1;
         end else if (rel && !acc) begin
            total_q <= total_q - 1'b1;
         end
         if (rsp_hs && (cnt_q[wresp_id_i] == '0)) begin
            err_q <= 1'b1;
         end
      end
   end

`ifdef SIMMEM_LIMITER_STATS_EN
   logic [31:0] stall_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_q <= '0;
      end else if (waddr_in_valid_i && !admit && (stall_q != '1)) begin
         stall_q <= stall_q + 1'b1;
      end
   end

   assign stall_cycles_o = stall_q;
`else
   assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_simmem_wr_outstanding_limiter.sv
// Scoreboarded bench for simmem_wr_outstanding_limiter (default parameters: 8 IDs, 4 per ID, 16 total).
// Expected accepted requests are queued when driven and popped at the controller-side handshake.

module tb_simmem_wr_outstanding_limiter;

   localparam int unsigned IDW = simmem_pkg::IDWidth;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   in_valid;
   logic                   in_ready;
   simmem_pkg::waddr_req_t data_in;
   logic                   out_valid;
   logic                   out_ready;
   simmem_pkg::waddr_req_t data_out;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [IDW-1:0]         rsp_id;
   logic [4:0]             total;
   logic                   uerr;
   logic [31:0]            stalls;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   simmem_pkg::waddr_req_t exp_q[$];

   simmem_wr_outstanding_limiter #(
      .IDWidth (IDW),
      .MaxPerId(4),
      .MaxTotal(16)
   ) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .waddr_in_valid_i   (in_valid),
      .waddr_in_ready_o   (in_ready),
      .waddr_data_i       (data_in),
      .waddr_out_valid_o  (out_valid),
      .waddr_out_ready_i  (out_ready),
      .waddr_data_o       (data_out),
      .wresp_valid_i      (rsp_valid),
      .wresp_ready_i      (rsp_ready),
      .wresp_id_i         (rsp_id),
      .total_outstanding_o(total),
      .underflow_err_o    (uerr),
      .stall_cycles_o     (stalls)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Every controller-side handshake must match the oldest request the bench expected to pass.
   always @(posedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_accept", 64'(data_out), 64'hDEAD);
         end else begin
            chk("accepted_req", 64'(data_out), 64'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input int unsigned id);
      in_valid       = 1'b1;
      out_ready      = 1'b1;
      data_in.id     = IDW'(id);
      data_in.addr   = $urandom;
      data_in.burst_len = 8'($urandom_range(0, 15));
   endtask

   // One write attempt lasting a single cycle; gating is checked before the edge.
   task automatic wr(input int unsigned id, input logic exp_ok);
      drive_req(id);
      #1;
      chk("out_valid", 64'(out_valid), 64'(exp_ok));
      chk("in_ready", 64'(in_ready), 64'(exp_ok));
      if (exp_ok) exp_q.push_back(data_in);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic rsp(input int unsigned id);
      rsp_valid = 1'b1;
      rsp_ready = 1'b1;
      rsp_id    = IDW'(id);
      tick();
      rsp_valid = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      data_in   = '0;
      rsp_valid = 1'b0;
      rsp_ready = 1'b0;
      rsp_id    = '0;

      // Reset: zero state, gate transparent.
      #2;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("rst_total", 64'(total), 64'd0);
      chk("rst_err", 64'(uerr), 64'd0);
      chk("rst_stall", 64'(stalls), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd1);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();

      // Fill ID 3, then hold a blocked ID 3 request for 10 cycles.
      for (int i = 0; i < 4; i++) wr(3, 1'b1);
      chk("total_id3_full", 64'(total), 64'd4);
      drive_req(3);
      for (int i = 0; i < 10; i++) begin
         #1;
         chk("blk_out_valid", 64'(out_valid), 64'd0);
         chk("blk_in_ready", 64'(in_ready), 64'd0);
         tick();
      end
`ifdef SIMMEM_LIMITER_STATS_EN
      chk("stall_cycles", 64'(stalls), 64'd10);
`else
      chk("stall_cycles", 64'(stalls), 64'd0);
`endif

      // Release ID 3 while the request waits: freed slot usable only in the next cycle.
      rsp_valid = 1'b1;
      rsp_ready = 1'b1;
      rsp_id    = IDW'(3);
      #1;
      chk("same_cycle_release_blocked", 64'(out_valid), 64'd0);
      tick();
      rsp_valid = 1'b0;
      chk("total_after_rel", 64'(total), 64'd3);
      chk("unblocked_valid", 64'(out_valid), 64'd1);
      exp_q.push_back(data_in);
      tick();
      in_valid = 1'b0;
      chk("total_refill", 64'(total), 64'd4);

      // Global limit: IDs 0..2 filled to reach 16, ID 5 then blocked.
      for (int id = 0; id < 3; id++) for (int i = 0; i < 4; i++) wr(id, 1'b1);
      chk("total_full", 64'(total), 64'd16);
      drive_req(5);
      #1;
      chk("id5_blocked", 64'(out_valid), 64'd0);
      rsp_valid = 1'b1;
      rsp_ready = 1'b1;
      rsp_id    = IDW'(0);
      tick();
      rsp_valid = 1'b0;
      chk("id5_unblocked", 64'(out_valid), 64'd1);
      exp_q.push_back(data_in);
      tick();
      in_valid = 1'b0;
      chk("total_16_again", 64'(total), 64'd16);

      // Drain ID 0 (3 left) and ID 2 down to one outstanding.
      for (int i = 0; i < 3; i++) rsp(0);
      for (int i = 0; i < 3; i++) rsp(2);
      chk("total_drained", 64'(total), 64'd10);

      // Same-cycle accept and release of ID 2 with count 1.
      drive_req(2);
      rsp_valid = 1'b1;
      rsp_ready = 1'b1;
      rsp_id    = IDW'(2);
      #1;
      chk("acc_rel_valid", 64'(out_valid), 64'd1);
      exp_q.push_back(data_in);
      tick();
      in_valid  = 1'b0;
      rsp_valid = 1'b0;
      chk("acc_rel_total", 64'(total), 64'd10);
      // ID 2 still at 1: three more fit, the fourth hits the per-ID limit.
      for (int i = 0; i < 3; i++) wr(2, 1'b1);
      wr(2, 1'b0);
      chk("total_id2_full", 64'(total), 64'd13);

      // Underflow on ID 7: sticky, counts untouched.
      chk("err_before", 64'(uerr), 64'd0);
      rsp(7);
      chk("err_set", 64'(uerr), 64'd1);
      chk("total_after_uflow", 64'(total), 64'd13);
      wr(7, 1'b1);
      tick();
      tick();
      chk("err_sticky", 64'(uerr), 64'd1);
      chk("total_id7", 64'(total), 64'd14);

      // Reset pulse clears everything; a stale response then underflows.
      rst = 1'b1;
      #2;
      chk("rst2_total", 64'(total), 64'd0);
      chk("rst2_err", 64'(uerr), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      rsp(3);
      chk("stale_rsp_err", 64'(uerr), 64'd1);
      chk("stale_rsp_total", 64'(total), 64'd0);

      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
